// File: rtl/debug_trace_serializer.sv
// debug_trace_serializer: folds up to two in-order retirements per cycle onto a single registered debug write port.
module debug_trace_serializer #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in0_valid,
  input  logic [31:0]                in0_pc,
  input  logic [4:0]                 in0_wnum,
  input  logic [31:0]                in0_wdata,
  input  logic                       in1_valid,
  input  logic [31:0]                in1_pc,
  input  logic [4:0]                 in1_wnum,
  input  logic [31:0]                in1_wdata,
  output logic                       in_ready,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata,
  output logic [$clog2(DEPTH):0]     pending
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } entry_t;
  entry_t         mem [DEPTH];
  entry_t         e0, e1, first, store_a, out_next;
  logic [AW-1:0]  head, tail;
  logic           acc0, acc1, empty;
  logic [1:0]     n_store;
  assign in_ready = pending <= CW'(DEPTH - 2);
  always_comb begin
    e0       = {in0_pc, in0_wnum, in0_wdata};
    e1       = {in1_pc, in1_wnum, in1_wdata};
    acc0     = in0_valid && in_ready;
    acc1     = in1_valid && in_ready;
    empty    = pending == '0;
    first    = acc0 ? e0 : e1;
    // with an empty queue the oldest accepted entry bypasses straight to the output
    store_a  = empty ? e1 : first;
    n_store  = empty ? {1'b0, acc0 && acc1} : {1'b0, acc0} + {1'b0, acc1};
    out_next = !empty ? mem[head] : (acc0 || acc1) ? first : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset && n_store != 2'd0) mem[tail] <= store_a;
    if (!reset && n_store == 2'd2) mem[tail + AW'(1)] <= e1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head              <= '0;
      tail              <= '0;
      pending           <= '0;
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end else begin
      head              <= head + AW'(!empty);
      tail              <= tail + AW'(n_store);
      pending           <= pending + CW'(n_store) - CW'(!empty);
      debug_wb_pc       <= out_next.pc;
      debug_wb_rf_wen   <= |out_next.wnum ? 4'hF : 4'h0;
      debug_wb_rf_wnum  <= out_next.wnum;
      debug_wb_rf_wdata <= out_next.wdata;
    end
  end
endmodule

// File: tb/tb_debug_trace_serializer.sv
// tb_debug_trace_serializer: directed-vector bench for debug_trace_serializer with DEPTH = 8.
module tb_debug_trace_serializer;
  logic        clk = 0, reset = 1;
  logic        in0_valid = 0, in1_valid = 0;
  logic [31:0] in0_pc = 0, in0_wdata = 0, in1_pc = 0, in1_wdata = 0;
  logic [4:0]  in0_wnum = 0, in1_wnum = 0;
  logic        in_ready;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [3:0]  pending;
  int vecs = 0, errs = 0;

  debug_trace_serializer #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .in0_valid(in0_valid), .in0_pc(in0_pc), .in0_wnum(in0_wnum), .in0_wdata(in0_wdata),
    .in1_valid(in1_valid), .in1_pc(in1_pc), .in1_wnum(in1_wnum), .in1_wdata(in1_wdata),
    .in_ready(in_ready), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_pc"}, debug_wb_pc, 32'h0);
    chk({tag, "_wen"}, 32'(debug_wb_rf_wen), 32'h0);
    chk({tag, "_wnum"}, 32'(debug_wb_rf_wnum), 32'h0);
    chk({tag, "_wdata"}, debug_wb_rf_wdata, 32'h0);
  endtask

  initial begin
    #1;
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_pending", 32'(pending), 32'h0);
    chk_idle("rst");
    tick();
    tick();
    reset = 0;
    tick();
    chk_idle("post_rst");

    in0_valid = 1; in0_pc = 32'hBFC00000; in0_wnum = 2; in0_wdata = 32'h1234;
    tick();
    in0_valid = 0;
    chk("single_pc", debug_wb_pc, 32'hBFC00000);
    chk("single_wen", 32'(debug_wb_rf_wen), 32'hF);
    chk("single_wnum", 32'(debug_wb_rf_wnum), 32'd2);
    chk("single_wdata", debug_wb_rf_wdata, 32'h1234);
    chk("single_pending", 32'(pending), 32'h0);
    tick();
    chk_idle("single_after");

    in0_valid = 1; in0_pc = 32'hBFC00010; in0_wnum = 3; in0_wdata = 32'hAAAA0003;
    in1_valid = 1; in1_pc = 32'hBFC00014; in1_wnum = 4; in1_wdata = 32'hBBBB0004;
    tick();
    in0_valid = 0; in1_valid = 0;
    chk("dual1_pc", debug_wb_pc, 32'hBFC00010);
    chk("dual1_wnum", 32'(debug_wb_rf_wnum), 32'd3);
    chk("dual1_wdata", debug_wb_rf_wdata, 32'hAAAA0003);
    chk("dual1_pending", 32'(pending), 32'd1);
    tick();
    chk("dual2_pc", debug_wb_pc, 32'hBFC00014);
    chk("dual2_wnum", 32'(debug_wb_rf_wnum), 32'd4);
    chk("dual2_wdata", debug_wb_rf_wdata, 32'hBBBB0004);
    chk("dual2_pending", 32'(pending), 32'd0);
    tick();
    chk_idle("dual_after");

    in0_valid = 1; in0_pc = 32'hBFC00020; in0_wnum = 0; in0_wdata = 32'hFFFFFFFF;
    tick();
    in0_valid = 0;
    chk("r0_pc", debug_wb_pc, 32'hBFC00020);
    chk("r0_wen", 32'(debug_wb_rf_wen), 32'h0);
    chk("r0_wnum", 32'(debug_wb_rf_wnum), 32'h0);
    chk("r0_wdata", debug_wb_rf_wdata, 32'hFFFFFFFF);

    in1_valid = 1; in1_pc = 32'h2000; in1_wnum = 5; in1_wdata = 32'h55;
    tick();
    in1_valid = 0;
    chk("in1only_pc", debug_wb_pc, 32'h2000);
    chk("in1only_wen", 32'(debug_wb_rf_wen), 32'hF);
    chk("in1only_pending", 32'(pending), 32'h0);
    tick();
    chk_idle("in1only_after");

    // fill: 7 dual cycles take pending from 0 to 7
    for (int i = 0; i < 7; i++) begin
      chk("fill_ready", 32'(in_ready), 32'h1);
      in0_valid = 1; in0_pc = 32'h1000 + 32'(8 * i); in0_wnum = 1; in0_wdata = 32'(i);
      in1_valid = 1; in1_pc = 32'h1004 + 32'(8 * i); in1_wnum = 1; in1_wdata = 32'(i);
      tick();
      chk("fill_pc", debug_wb_pc, 32'h1000 + 32'(4 * i));
      chk("fill_pending", 32'(pending), 32'(i + 1));
    end
    in0_pc = 32'hDEAD0000; in1_pc = 32'hDEAD0004;
    chk("full_ready", 32'(in_ready), 32'h0);
    tick();
    chk("hold_pc", debug_wb_pc, 32'h101C);
    chk("hold_pending", 32'(pending), 32'd6);
    chk("hold_ready", 32'(in_ready), 32'h1);
    in0_valid = 0; in1_valid = 0;
    for (int k = 8; k < 14; k++) begin
      tick();
      chk("drain_pc", debug_wb_pc, 32'h1000 + 32'(4 * k));
    end
    chk("drain_pending", 32'(pending), 32'h0);
    tick();
    chk_idle("drain_after");

    for (int i = 0; i < 5; i++) begin
      in0_valid = 1; in0_pc = 32'h5000 + 32'(8 * i); in0_wnum = 7;
      in1_valid = 1; in1_pc = 32'h5004 + 32'(8 * i); in1_wnum = 8;
      tick();
    end
    in0_valid = 0; in1_valid = 0;
    chk("pre_rst_pending", 32'(pending), 32'd5);
    #2 reset = 1;
    #1;
    chk("arst_pending", 32'(pending), 32'h0);
    chk("arst_ready", 32'(in_ready), 32'h1);
    chk_idle("arst");
    tick();
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_stale_pc", debug_wb_pc, 32'h0);
    end
    chk("no_stale_pending", 32'(pending), 32'h0);
    in0_valid = 1; in0_pc = 32'h3000; in0_wnum = 9; in0_wdata = 32'h77;
    tick();
    in0_valid = 0;
    chk("post_arst_pc", debug_wb_pc, 32'h3000);
    chk("post_arst_wen", 32'(debug_wb_rf_wen), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/debug_trace_serializer.md
DEBUG_TRACE_SERIALIZER -- requirements
Module: debug_trace_serializer

Interface
REQ-001 Parameter DEPTH, default 8, meaning stored-entry capacity of the internal queue; SHALL be a power of two, minimum 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in0_valid  input  1  older retirement of this cycle present.
REQ-005 in0_pc / in0_wnum / in0_wdata  input  32 / 5 / 32  PC, destination register index, write data of older retirement.
REQ-006 in1_valid  input  1  younger retirement of this cycle present.
REQ-007 in1_pc / in1_wnum / in1_wdata  input  32 / 5 / 32  same fields for younger retirement.
REQ-008 in_ready  output  1  both input slots may be accepted this cycle.
REQ-009 debug_wb_pc  output  32  traced PC.
REQ-010 debug_wb_rf_wen  output  4  byte-enable strobe of traced write.
REQ-011 debug_wb_rf_wnum  output  5  traced register index.
REQ-012 debug_wb_rf_wdata  output  32  traced write data.
REQ-013 pending  output  $clog2(DEPTH)+1  number of entries stored, not yet presented.

Function
REQ-014 Block SHALL serialize up to two retirements per cycle onto the single-write-per-cycle debug trace port, preserving program order.
REQ-015 in_ready SHALL be combinational: 1 iff (DEPTH - pending) >= 2; independent of in0_valid/in1_valid.
REQ-016 Slot k SHALL be accepted iff ink_valid && in_ready; no slot is accepted when in_ready = 0 and inputs are ignored (sender holds).
REQ-017 Order: accepted in0 precedes accepted in1 of the same cycle; entries of cycle t precede entries of cycle t+1; in1 alone (in0_valid = 0) is legal and accepted as a single entry.
REQ-018 Debug outputs SHALL be registered; each rising edge loads exactly one entry if any is available, else the idle value.
REQ-019 Source for the output register at each edge, in priority: oldest stored entry; else oldest accepted entry of this cycle (bypass); else idle.
REQ-020 Accepted entries not consumed by the bypass SHALL be stored in order; simultaneous store (0-2) and load (0-1) in one cycle SHALL be supported; pending updates as pending + stored - loaded-from-queue.
REQ-021 Latency: with pending = 0, an entry accepted in cycle t SHALL appear on outputs in cycle t+1; the second of a dual acceptance in cycle t+2.
REQ-022 debug_wb_rf_wen SHALL equal 4'hF when entry wnum != 0 and 4'h0 when wnum = 0; pc, wnum, wdata are still presented unchanged for wnum = 0.
REQ-023 Idle value: debug_wb_pc = 0, wen = 4'h0, wnum = 0, wdata = 0; each idle cycle drives this value (no hold of previous entry).
REQ-024 Each entry SHALL be presented for exactly one cycle; no duplication, no loss.
REQ-025 Queue pointers SHALL wrap modulo DEPTH; full (pending = DEPTH) and empty (pending = 0) distinguished by the count; storing into a full queue cannot occur by REQ-015.

Reset
REQ-026 While reset = 1, at any time including mid-burst: pending = 0, queue pointers = 0, all debug outputs at idle value, in_ready = 1; all stored entries discarded.
REQ-027 First edge after reset release SHALL behave as REQ-019 with an empty queue.

Verification
REQ-028 Single: in0 {pc 0xBFC00000, wnum 2, wdata 0x1234} one cycle, pending 0 -> next cycle pc 0xBFC00000, wen 4'hF, wnum 2, wdata 0x1234; following cycle idle.
REQ-029 Dual: in0 pc 0xBFC00010 wnum 3, in1 pc 0xBFC00014 wnum 4 same cycle -> t+1 shows 0xBFC00010, t+2 shows 0xBFC00014, pending 1 during t+1, 0 at t+2.
REQ-030 R0 write: in0 wnum 0, pc 0xBFC00020, wdata 0xFFFFFFFF -> next cycle pc 0xBFC00020, wen 4'h0, wnum 0, wdata 0xFFFFFFFF.
REQ-031 Fill (DEPTH 8): dual valid every cycle, sequential PCs from 0x1000 step 4 -> in_ready drops to 0 when pending reaches 7; upon dropping valids, outputs drain all PCs consecutively with no gap, loss or reorder; in_ready returns when pending <= 6.
REQ-032 in1-only: in0_valid 0, in1 pc 0x2000 wnum 5 -> next cycle pc 0x2000, wen 4'hF.
REQ-033 Reset mid-operation: assert reset with pending = 5 -> outputs idle and pending 0 immediately (asynchronous); after release, no stale entry ever appears on outputs.
